rx_frame_packer: RTL

Downstream of the receiver DDC chain. Buffers the 24-bit I/Q sample pairs the receiver emits on its output strobe and serialises them into fixed 512-byte host frames on a byte-wide valid/ready stream toward the Ethernet/USB transmit path. Each frame carries 3 sync bytes, 5 control bytes and 63 eight-byte sample slots. A frame is started only when a whole frame of samples is buffered, so a frame never stalls on missing data.

---
 rtl/rx_frame_packer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_packer.sv
// Sample-pair FIFO plus a frame serialiser: 3 sync bytes, 5 control bytes and
// SAMPLES_PER_FRAME eight-byte I/Q slots on a byte-wide valid/ready stream.
module rx_frame_packer #(
    parameter int FIFO_DEPTH        = 128,
    parameter int SAMPLES_PER_FRAME = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_strobe,
    input  logic [23:0] in_data_I,
    input  logic [23:0] in_data_Q,
    input  logic [39:0] ctrl_bytes,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int FRAME_BYTES = 8 + 8 * SAMPLES_PER_FRAME;
    localparam int CW = $clog2(FRAME_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [CW-1:0] LAST_BYTE   = CW'(FRAME_BYTES - 1);
    localparam logic [OW-1:0] FULL_LEVEL  = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] FRAME_LEVEL = OW'(SAMPLES_PER_FRAME);

    typedef enum logic [1:0] {IDLE, SYNC, CTRL, SAMPLE} state_t;

    logic [47:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ, occ_next;
    logic          wr_en, drop, accept, pop, start;
    logic [47:0]   head;

    state_t        state, state_next;
    logic [CW-1:0] byte_cnt, cnt_next, nxt_idx;
    logic [39:0]   ctrl_lat;
    logic [7:0]    data_next;
    logic          valid_next, sof_next, eof_next;

    function automatic logic [7:0] frame_byte(input logic [CW-1:0] idx,
                                              input logic [39:0] ctrl,
                                              input logic [47:0] smp);
        logic [7:0] b;
        b = 8'h00;
        if (idx < CW'(3)) begin
            b = 8'h7F;
        end else if (idx < CW'(8)) begin
            case (idx[2:0])
                3'd3:    b = ctrl[39:32];
                3'd4:    b = ctrl[31:24];
                3'd5:    b = ctrl[23:16];
                3'd6:    b = ctrl[15:8];
                default: b = ctrl[7:0];
            endcase
        end else begin
            case (idx[2:0])
                3'd0:    b = smp[47:40];
                3'd1:    b = smp[39:32];
                3'd2:    b = smp[31:24];
                3'd3:    b = smp[23:16];
                3'd4:    b = smp[15:8];
                3'd5:    b = smp[7:0];
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    function automatic state_t state_of(input logic [CW-1:0] idx);
        if (idx < CW'(3)) return SYNC;
        if (idx < CW'(8)) return CTRL;
        return SAMPLE;
    endfunction

    // Full check uses start-of-cycle occupancy, so a same-cycle pop never frees room.
    assign wr_en    = in_strobe && (occ < FULL_LEVEL);
    assign drop     = in_strobe && !(occ < FULL_LEVEL);
    assign accept   = out_valid && out_ready;
    assign pop      = accept && (state == SAMPLE) && (byte_cnt[2:0] == 3'd7);
    assign occ_next = occ + {{(OW-1){1'b0}}, wr_en} - {{(OW-1){1'b0}}, pop};
    assign head     = pop ? mem[rd_ptr + PW'(1)] : mem[rd_ptr];
    assign nxt_idx  = byte_cnt + CW'(1);

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= {in_data_I, in_data_Q};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            occ      <= occ_next;
            overflow <= drop;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // Outputs are registered: the next byte is computed here and loaded on acceptance.
    always_comb begin
        state_next = state;
        cnt_next   = byte_cnt;
        data_next  = out_data;
        valid_next = out_valid;
        sof_next   = out_sof;
        eof_next   = out_eof;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (occ >= FRAME_LEVEL) start = 1'b1;
            end
            default: begin
                if (accept) begin
                    if (byte_cnt == LAST_BYTE) begin
                        if (occ_next >= FRAME_LEVEL) begin
                            start = 1'b1;
                        end else begin
                            state_next = IDLE;
                            valid_next = 1'b0;
                            data_next  = 8'h00;
                            sof_next   = 1'b0;
                            eof_next   = 1'b0;
                        end
                    end else begin
                        cnt_next   = nxt_idx;
                        state_next = state_of(nxt_idx);
                        data_next  = frame_byte(nxt_idx, ctrl_lat, head);
                        sof_next   = 1'b0;
                        eof_next   = (nxt_idx == LAST_BYTE);
                    end
                end
            end
        endcase
        if (start) begin
            state_next = SYNC;
            cnt_next   = '0;
            data_next  = 8'h7F;
            valid_next = 1'b1;
            sof_next   = 1'b1;
            eof_next   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            ctrl_lat  <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            state     <= state_next;
            byte_cnt  <= cnt_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            out_sof   <= sof_next;
            out_eof   <= eof_next;
            if (start) ctrl_lat <= ctrl_bytes;
        end
    end

endmodule
